// File: rtl/messbauer_diff_discriminator_counter.sv
// Differential discriminator back end. It synchronises the threshold and channel inputs, classifies
// each impulse, counts the accepted ones per Messbauer channel, and hands each count out over valid/ready.
module messbauer_diff_discriminator_counter #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned COUNTER_WIDTH   = 16,
    parameter int unsigned MIN_LOWER_WIDTH = 1,
    parameter int unsigned MAX_LOWER_WIDTH = 64
) (
    input  logic                     aclk,
    input  logic                     areset_n,
    input  logic                     lower_threshold_i,
    input  logic                     upper_threshold_i,
    input  logic                     channel_i,
    input  logic                     enable_i,
    output logic                     accepted_o,
    output logic                     rejected_o,
    output logic [COUNTER_WIDTH-1:0] count_data_o,
    output logic                     count_valid_o,
    input  logic                     count_ready_i,
    output logic                     overflow_o,
    output logic                     window_lost_o
);

    localparam logic [7:0]               MinWidth = 8'(MIN_LOWER_WIDTH);
    localparam logic [7:0]               MaxWidth = 8'(MAX_LOWER_WIDTH);
    localparam logic [COUNTER_WIDTH-1:0] AccMax   = '1;

    typedef enum logic [1:0] {StIdle, StLowerHigh, StStuck} state_e;

    logic [SYNC_STAGES-1:0]   lo_sync_q, up_sync_q, ch_sync_q;
    logic                     lo_s, up_s, ch_s, ch_s_d_q, ch_rise;
    state_e                   state_q;
    logic [7:0]               wcnt_q;
    logic                     up_flag_q;
    logic                     accepted_q, rejected_q;
    logic [COUNTER_WIDTH-1:0] acc_q, count_data_q;
    logic                     ovf_acc_q, overflow_q, count_valid_q, window_lost_q;
    logic                     out_free;

    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            lo_sync_q <= '0;
            up_sync_q <= '0;
            ch_sync_q <= '0;
        end else begin
            lo_sync_q <= {lo_sync_q[SYNC_STAGES-2:0], lower_threshold_i};
            up_sync_q <= {up_sync_q[SYNC_STAGES-2:0], upper_threshold_i};
            ch_sync_q <= {ch_sync_q[SYNC_STAGES-2:0], channel_i};
        end
    end

    assign lo_s     = lo_sync_q[SYNC_STAGES-1];
    assign up_s     = up_sync_q[SYNC_STAGES-1];
    assign ch_s     = ch_sync_q[SYNC_STAGES-1];
    assign ch_rise  = ch_s & ~ch_s_d_q;
    assign out_free = ~count_valid_q | count_ready_i;

    // Impulse classifier. wcnt_q holds the number of synchronised lower-high cycles seen so far.
    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            state_q    <= StIdle;
            wcnt_q     <= '0;
            up_flag_q  <= 1'b0;
            accepted_q <= 1'b0;
            rejected_q <= 1'b0;
        end else begin
            accepted_q <= 1'b0;
            rejected_q <= 1'b0;
            if (!enable_i) begin
                state_q <= StIdle;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (lo_s) begin
                            state_q   <= StLowerHigh;
                            wcnt_q    <= 8'd1;
                            up_flag_q <= up_s;
                        end
                    end
                    StLowerHigh: begin
                        if (!lo_s) begin
                            state_q <= StIdle;
                            if (!up_flag_q && !up_s && (wcnt_q >= MinWidth)) begin
                                accepted_q <= 1'b1;
                            end else begin
                                rejected_q <= 1'b1;
                            end
                        end else if (wcnt_q == MaxWidth) begin
                            rejected_q <= 1'b1;
                            state_q    <= StStuck;
                        end else begin
                            if (wcnt_q != 8'hff) begin
                                wcnt_q <= wcnt_q + 8'd1;
                            end
                            if (up_s) begin
                                up_flag_q <= 1'b1;
                            end
                        end
                    end
                    StStuck: begin
                        if (!lo_s) begin
                            state_q <= StIdle;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    // Per-channel accumulator and the output holding register. A channel edge always closes the
    // window; if the previous count has not been taken yet, the new one is dropped.
    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            ch_s_d_q      <= 1'b0;
            acc_q         <= '0;
            ovf_acc_q     <= 1'b0;
            count_data_q  <= '0;
            overflow_q    <= 1'b0;
            count_valid_q <= 1'b0;
            window_lost_q <= 1'b0;
        end else begin
            ch_s_d_q      <= ch_s;
            window_lost_q <= 1'b0;
            if (ch_rise) begin
                acc_q     <= COUNTER_WIDTH'(accepted_q);
                ovf_acc_q <= 1'b0;
                if (out_free) begin
                    count_data_q  <= acc_q;
                    overflow_q    <= ovf_acc_q;
                    count_valid_q <= 1'b1;
                end else begin
                    window_lost_q <= 1'b1;
                end
            end else begin
                if (accepted_q) begin
                    if (acc_q == AccMax) begin
                        ovf_acc_q <= 1'b1;
                    end else begin
                        acc_q <= acc_q + 1'b1;
                    end
                end
                if (count_valid_q && count_ready_i) begin
                    count_valid_q <= 1'b0;
                end
            end
        end
    end

    assign accepted_o    = accepted_q;
    assign rejected_o    = rejected_q;
    assign count_data_o  = count_data_q;
    assign count_valid_o = count_valid_q;
    assign overflow_o    = overflow_q;
    assign window_lost_o = window_lost_q;

endmodule

// File: tb/tb_messbauer_diff_discriminator_counter.sv
// Bench for messbauer_diff_discriminator_counter: a table of impulse shapes, hand sequences for the
// multi-cycle corners, and random impulses checked against a pin-level classification model.
module tb_messbauer_diff_discriminator_counter;

    localparam int MinW = 2;
    localparam int MaxW = 64;

    logic        aclk = 1'b0;
    logic        areset_n, lower, upper, channel, enable, ready;
    logic        acc, rej, valid, ovf, lost;
    logic [15:0] data;
    logic        acc4, rej4, valid4, ovf4, lost4;
    logic [3:0]  data4;

    always #10 aclk = ~aclk;

    messbauer_diff_discriminator_counter #(
        .SYNC_STAGES(2), .COUNTER_WIDTH(16), .MIN_LOWER_WIDTH(MinW), .MAX_LOWER_WIDTH(MaxW)
    ) u_dut (
        .aclk(aclk), .areset_n(areset_n), .lower_threshold_i(lower), .upper_threshold_i(upper),
        .channel_i(channel), .enable_i(enable), .accepted_o(acc), .rejected_o(rej),
        .count_data_o(data), .count_valid_o(valid), .count_ready_i(ready), .overflow_o(ovf),
        .window_lost_o(lost)
    );

    messbauer_diff_discriminator_counter #(
        .SYNC_STAGES(2), .COUNTER_WIDTH(4), .MIN_LOWER_WIDTH(MinW), .MAX_LOWER_WIDTH(MaxW)
    ) u_dut4 (
        .aclk(aclk), .areset_n(areset_n), .lower_threshold_i(lower), .upper_threshold_i(upper),
        .channel_i(channel), .enable_i(enable), .accepted_o(acc4), .rejected_o(rej4),
        .count_data_o(data4), .count_valid_o(valid4), .count_ready_i(ready), .overflow_o(ovf4),
        .window_lost_o(lost4)
    );

    int total = 0;
    int bad   = 0;
    int m_acc = 0;  // accepted impulses in the current window, unbounded

    int          n_acc = 0, n_rej = 0, n_lost = 0, n_valid = 0, n_hs = 0, n_hs4 = 0;
    logic [15:0] hs_data = '0;
    logic        hs_ovf = 1'b0;
    logic [3:0]  hs_data4 = '0;
    logic        hs_ovf4 = 1'b0;

    always @(negedge aclk) begin
        if (acc)   n_acc   <= n_acc + 1;
        if (rej)   n_rej   <= n_rej + 1;
        if (lost)  n_lost  <= n_lost + 1;
        if (valid) n_valid <= n_valid + 1;
        if (valid && ready) begin
            n_hs    <= n_hs + 1;
            hs_data <= data;
            hs_ovf  <= ovf;
        end
        if (valid4 && ready) begin
            n_hs4    <= n_hs4 + 1;
            hs_data4 <= data4;
            hs_ovf4  <= ovf4;
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    // Reference classification from pin-level waveforms: lower high on cycles [0, width),
    // upper high on [us, us+ul). Upper anywhere from the rise through the falling cycle rejects.
    function automatic bit model_accept(input int width, input int us, input int ul);
        if (width < MinW || width > MaxW) return 1'b0;
        if (ul > 0 && us <= width && us + ul - 1 >= 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic run_impulse(input string name, input int width, input int us, input int ul,
                               input bit exp_acc);
        int a0, r0;
        a0 = n_acc;
        r0 = n_rej;
        for (int t = -3; t < width + 8; t++) begin
            lower = (t >= 0 && t < width);
            upper = (ul > 0 && t >= us && t < us + ul);
            tick(1);
        end
        lower = 1'b0;
        upper = 1'b0;
        tick(3);
        chk({name, " accepted"}, n_acc - a0, exp_acc ? 1 : 0);
        chk({name, " rejected"}, n_rej - r0, exp_acc ? 0 : 1);
        if (exp_acc) m_acc++;
    endtask

    task automatic channel_pulse(input string name);
        int h0, h40, v0;
        h0  = n_hs;
        h40 = n_hs4;
        v0  = n_valid;
        channel = 1'b1;
        tick(4);
        channel = 1'b0;
        tick(4);
        chk({name, " handshakes"}, n_hs - h0, 1);
        chk({name, " valid cycles"}, n_valid - v0, 1);
        chk({name, " count"}, hs_data, (m_acc > 65535) ? 65535 : m_acc);
        chk({name, " overflow"}, hs_ovf, (m_acc > 65535) ? 1 : 0);
        chk({name, " w4 handshakes"}, n_hs4 - h40, 1);
        chk({name, " w4 count"}, hs_data4, (m_acc > 15) ? 15 : m_acc);
        chk({name, " w4 overflow"}, hs_ovf4, (m_acc > 15) ? 1 : 0);
        m_acc = 0;
    endtask

    typedef struct {
        string name;
        int    width;
        int    us;
        int    ul;
        bit    exp_acc;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int a0, r0, l0, w, us, ul;

        vecs.push_back('{"clean3",       3,  0, 0, 1'b1});
        vecs.push_back('{"upper_inside", 4,  1, 1, 1'b0});
        vecs.push_back('{"glitch1",      1,  0, 0, 1'b0});
        vecs.push_back('{"min2",         2,  0, 0, 1'b1});
        vecs.push_back('{"upper_at_fall", 5, 5, 1, 1'b0});
        vecs.push_back('{"upper_after",  5,  6, 1, 1'b1});
        vecs.push_back('{"upper_before", 5, -2, 2, 1'b1});
        vecs.push_back('{"upper_at_rise", 5, -1, 2, 1'b0});
        vecs.push_back('{"max_width",   64,  0, 0, 1'b1});
        vecs.push_back('{"max_plus1",   65,  0, 0, 1'b0});

        areset_n = 1'b0;
        lower    = 1'b0;
        upper    = 1'b0;
        channel  = 1'b0;
        enable   = 1'b1;
        ready    = 1'b1;
        tick(3);
        chk("reset accepted", acc, 0);
        chk("reset rejected", rej, 0);
        chk("reset count_data", data, 0);
        chk("reset count_valid", valid, 0);
        chk("reset overflow", ovf, 0);
        chk("reset window_lost", lost, 0);
        areset_n = 1'b1;
        tick(3);

        foreach (vecs[i]) run_impulse(vecs[i].name, vecs[i].width, vecs[i].us, vecs[i].ul,
                                      vecs[i].exp_acc);
        channel_pulse("table window");

        // Accept latency: two synchroniser stages plus the registered pulse.
        lower = 1'b1;
        tick(3);
        lower = 1'b0;
        tick(2);
        chk("latency early", acc, 0);
        tick(1);
        chk("latency pulse", acc, 1);
        tick(1);
        chk("latency one cycle", acc, 0);
        m_acc++;
        tick(4);
        channel_pulse("single accept");

        for (int i = 0; i < 16; i++) run_impulse("burst16", 3, 0, 0, 1'b1);
        channel_pulse("count16");
        for (int i = 0; i < 20; i++) run_impulse("burst20", 4, 0, 0, 1'b1);
        channel_pulse("count20");

        // Reset mid-impulse: the remaining high part re-enters from idle and is accepted.
        run_impulse("pre_reset", 3, 0, 0, 1'b1);
        a0 = n_acc;
        r0 = n_rej;
        lower = 1'b1;
        tick(10);
        areset_n = 1'b0;
        tick(2);
        chk("mid reset count_data", data, 0);
        chk("mid reset count_valid", valid, 0);
        areset_n = 1'b1;
        m_acc = 0;
        tick(15);
        lower = 1'b0;
        tick(8);
        chk("reentry accepted", n_acc - a0, 1);
        chk("reentry rejected", n_rej - r0, 0);
        m_acc++;

        // Stuck lower: one reject at the width limit, nothing on release.
        a0 = n_acc;
        r0 = n_rej;
        lower = 1'b1;
        tick(70);
        chk("stuck rejected", n_rej - r0, 1);
        tick(30);
        lower = 1'b0;
        tick(8);
        chk("stuck release rejected", n_rej - r0, 1);
        chk("stuck release accepted", n_acc - a0, 0);

        // Disable mid-impulse drops it silently and keeps the accumulator.
        a0 = n_acc;
        r0 = n_rej;
        lower = 1'b1;
        tick(5);
        enable = 1'b0;
        tick(2);
        lower = 1'b0;
        tick(5);
        enable = 1'b1;
        tick(3);
        chk("disable accepted", n_acc - a0, 0);
        chk("disable rejected", n_rej - r0, 0);
        channel_pulse("after disable");

        // Output full: second edge is lost, first count held, lost window not carried over.
        ready = 1'b0;
        run_impulse("hold_a", 3, 0, 0, 1'b1);
        run_impulse("hold_b", 3, 0, 0, 1'b1);
        channel = 1'b1;
        tick(4);
        channel = 1'b0;
        tick(4);
        chk("held valid", valid, 1);
        chk("held data", data, 2);
        m_acc = 0;
        for (int i = 0; i < 3; i++) run_impulse("hold_c", 3, 0, 0, 1'b1);
        l0 = n_lost;
        channel = 1'b1;
        tick(4);
        channel = 1'b0;
        tick(4);
        chk("window_lost pulses", n_lost - l0, 1);
        chk("held data after lost", data, 2);
        chk("held valid after lost", valid, 1);
        m_acc = 0;
        ready = 1'b1;
        tick(3);
        chk("released data", hs_data, 2);
        chk("released valid", valid, 0);
        channel_pulse("after lost");

        for (int n = 0; n < 60; n++) begin
            w = (n % 10 == 9) ? int'($urandom_range(60, 72)) : int'($urandom_range(1, 40));
            if ($urandom_range(0, 1) == 0) begin
                us = 0;
                ul = 0;
            end else begin
                us = int'($urandom_range(0, w + 5)) - 3;
                ul = int'($urandom_range(1, 3));
            end
            run_impulse($sformatf("rand%0d w%0d us%0d ul%0d", n, w, us, ul), w, us, ul,
                        model_accept(w, us, ul));
            if (n % 8 == 7) channel_pulse($sformatf("rand window %0d", n));
        end
        channel_pulse("final window");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
